// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Fetches one 16-bit instruction as two bytes from an 8-bit memory. A fetch
// reads the byte at PC (hi byte), then the byte at PC+1 (lo byte). It then
// presents them to the instruction register on two consecutive load_ir
// strobes, hi byte first. The PC advances by one per byte read and wraps
// modulo 2^13. Every output comes straight from a flop.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   fetch_req  in   start one fetch (sampled only while idle)
//   pc_load    in   load pc_in into PC (only while idle, wins over fetch_req)
//   pc_in      in   13-bit jump target
//   mem_rd     out  byte read request, held until mem_ready
//   mem_addr   out  13-bit byte address (always equals pc_out)
//   mem_rdata  in   read byte, valid with mem_ready
//   mem_ready  in   read completion, any number of wait cycles
//   load_ir    out  instruction register byte strobe
//   ir_data    out  byte for the instruction register, held between strobes
//   pc_out     out  current PC
//   busy       out  high whenever not idle
//   fetch_done out  one-cycle pulse together with the lo byte strobe
// ----------------------------------------------------------------------------
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [12:0] pc_in,
    output logic        mem_rd,
    output logic [12:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        load_ir,
    output logic [7:0]  ir_data,
    output logic [12:0] pc_out,
    output logic        busy,
    output logic        fetch_done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        EMIT_HI,
        EMIT_LO
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] pc_q, pc_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic        mem_rd_q, mem_rd_d;
    logic        load_ir_q, load_ir_d;
    logic [7:0]  ir_data_q, ir_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // State and all output registers. Reset takes effect immediately and
    // aborts any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= 13'd0;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            mem_rd_q  <= 1'b0;
            load_ir_q <= 1'b0;
            ir_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mem_rd_q  <= mem_rd_d;
            load_ir_q <= load_ir_d;
            ir_data_q <= ir_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. mem_ready is consulted only in the read states, so a
    // stray completion while no read is outstanding is ignored. Requests that
    // arrive while busy are simply dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (fetch_req) begin
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                if (mem_ready) begin
                    hi_d    = mem_rdata;
                    pc_d    = pc_q + 13'd1;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (mem_ready) begin
                    lo_d    = mem_rdata;
                    pc_d    = pc_q + 13'd1;
                    state_d = EMIT_HI;
                end
            end
            EMIT_HI: state_d = EMIT_LO;
            EMIT_LO: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they belong to. ir_data only changes when
    // a strobe is about to be issued, so it holds between fetches.
    always_comb begin
        mem_rd_d  = (state_d == RD_HI) || (state_d == RD_LO);
        load_ir_d = (state_d == EMIT_HI) || (state_d == EMIT_LO);
        done_d    = (state_d == EMIT_LO);
        busy_d    = (state_d != IDLE);
        ir_data_d = ir_data_q;
        if (state_d == EMIT_HI) begin
            ir_data_d = hi_d;
        end else if (state_d == EMIT_LO) begin
            ir_data_d = lo_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = pc_q;
    assign pc_out     = pc_q;
    assign load_ir    = load_ir_q;
    assign ir_data    = ir_data_q;
    assign busy       = busy_q;
    assign fetch_done = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A behavioural byte memory answers read
// requests after a programmable number of wait cycles. Expected addresses and
// bytes are queued when a fetch is launched and are consumed when the design
// issues the matching read or instruction-register strobe.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_load;
    logic [12:0] pc_in;
    logic        mem_rd;
    logic [12:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        load_ir;
    logic [7:0]  ir_data;
    logic [12:0] pc_out;
    logic        busy;
    logic        fetch_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [0:8191];
    logic [12:0] expAddrQ [$];
    logic [7:0]  expByteQ [$];
    logic [12:0] pcModel;
    logic [12:0] heldAddr;
    int          waitStates;
    int          waitCnt;
    logic        forceReady;
    int          cyc;
    int          firstLoadCyc;
    int          loadCount;
    logic        pairPhase;

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .load_ir    (load_ir),
        .ir_data    (ir_data),
        .pc_out     (pc_out),
        .busy       (busy),
        .fetch_done (fetch_done)
    );

    // Free-running clock with a cycle counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: answers an outstanding read after waitStates cycles,
    // checks the address is held during waits and matches the queued one.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            waitCnt   = 0;
        end else if (mem_rd) begin
            if (waitCnt == 0) heldAddr = mem_addr;
            else checkOutput("mem_addr_stable", mem_addr, heldAddr);
            if (waitCnt >= waitStates) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr];
                waitCnt   = 0;
                if (expAddrQ.size() == 0) checkOutput("mem_rd_unexpected", mem_rd, 0);
                else checkOutput("mem_addr", mem_addr, expAddrQ.pop_front());
            end else begin
                mem_ready = 1'b0;
                waitCnt++;
            end
        end else begin
            mem_ready = forceReady;
            mem_rdata = 8'hEE;
            waitCnt   = 0;
        end
    end

    // Instruction-register monitor: every strobe must match the next queued
    // byte, and fetch_done must accompany exactly the second strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            pairPhase = 1'b0;
        end else if (load_ir) begin
            loadCount++;
            if (expByteQ.size() == 0) checkOutput("load_ir_unexpected", load_ir, 0);
            else checkOutput("ir_data", ir_data, expByteQ.pop_front());
            checkOutput("fetch_done_phase", fetch_done, pairPhase);
            if (pairPhase == 1'b0) firstLoadCyc = cyc;
            pairPhase = ~pairPhase;
        end else if (fetch_done) begin
            checkOutput("fetch_done_alone", fetch_done, 0);
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mem_rd"}, mem_rd, 0);
        checkOutput({tag, "_load_ir"}, load_ir, 0);
        checkOutput({tag, "_fetch_done"}, fetch_done, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ir_data"}, ir_data, 0);
        checkOutput({tag, "_pc_out"}, pc_out, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    // Assert reset mid-cycle, check outputs cleared at once, then release.
    task automatic applyReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkIdleOutputs("reset");
        expAddrQ.delete();
        expByteQ.delete();
        pcModel = 13'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic queueFetch(input logic [12:0] a0);
        logic [12:0] a1;
        a1 = a0 + 13'd1;
        expAddrQ.push_back(a0);
        expAddrQ.push_back(a1);
        expByteQ.push_back(mem[a0]);
        expByteQ.push_back(mem[a1]);
        pcModel = a0 + 13'd2;
    endtask

    task automatic waitFetchDone(input string tag);
        int n;
        n = 0;
        while (fetch_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_fetch_done_seen"}, fetch_done, 1);
    endtask

    // One complete fetch with the given wait states per byte.
    task automatic applyStimulus(input string tag, input int waits);
        int          reqCyc;
        int          loadsBefore;
        logic [7:0]  loByte;
        loByte      = mem[pcModel + 13'd1];
        waitStates  = waits;
        loadsBefore = loadCount;
        queueFetch(pcModel);
        @(negedge clk);
        fetch_req = 1'b1;
        reqCyc    = cyc;
        @(negedge clk);
        fetch_req = 1'b0;
        waitFetchDone(tag);
        checkOutput({tag, "_latency"}, firstLoadCyc - reqCyc, 3 + 2 * waits);
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_pc_out"}, pc_out, pcModel);
        checkOutput({tag, "_load_count"}, loadCount - loadsBefore, 2);
        checkOutput({tag, "_ir_hold"}, ir_data, loByte);
    endtask

    initial begin
        int n;
        logic [12:0] a1;
        int loadsBefore;

        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 13);
        mem[13'h0000] = 8'hA5;
        mem[13'h0001] = 8'h3C;
        mem[13'h0002] = 8'h5A;
        mem[13'h0003] = 8'hC3;
        mem[13'h1FFF] = 8'h7E;

        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        pc_load    = 1'b0;
        pc_in      = 13'd0;
        forceReady = 1'b0;
        waitStates = 0;
        loadCount  = 0;
        firstLoadCyc = 0;
        pcModel    = 13'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 8'h00;

        #12 checkIdleOutputs("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Zero-wait fetch of 0xA5, 0x3C.
        applyStimulus("fetch0", 0);

        // Same fetch with three wait cycles per byte.
        applyReset();
        applyStimulus("fetch3w", 3);

        // Completions while no read is outstanding must be ignored.
        @(negedge clk);
        forceReady = 1'b1;
        repeat (3) @(negedge clk);
        forceReady = 1'b0;
        checkOutput("stray_ready_pc", pc_out, pcModel);
        checkOutput("stray_ready_busy", busy, 0);

        // pc_load beats fetch_req in the same cycle.
        @(negedge clk);
        pc_load   = 1'b1;
        fetch_req = 1'b1;
        pc_in     = 13'h1FFF;
        @(negedge clk);
        pc_load   = 1'b0;
        fetch_req = 1'b0;
        checkOutput("pc_load_pc", pc_out, 13'h1FFF);
        checkOutput("pc_load_no_fetch", busy, 0);
        pcModel = 13'h1FFF;
        @(negedge clk);
        checkOutput("pc_load_still_idle", mem_rd, 0);

        // Fetch across the 13-bit wrap: 0x1FFF then 0x0000.
        applyStimulus("wrap", 0);

        // Requests while busy (in RD_LO) are dropped, not queued.
        waitStates  = 2;
        loadsBefore = loadCount;
        a1 = pcModel + 13'd1;
        queueFetch(pcModel);
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        n = 0;
        while (!(mem_rd === 1'b1 && mem_addr === a1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_req_reached_rd_lo", mem_addr, a1);
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_in     = 13'h0100;
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        waitFetchDone("busy_req");
        repeat (8) @(negedge clk);
        checkOutput("busy_req_pc", pc_out, pcModel);
        checkOutput("busy_req_loads", loadCount - loadsBefore, 2);
        checkOutput("busy_req_idle", busy, 0);

        // Reset during RD_LO aborts the fetch.
        waitStates  = 3;
        loadsBefore = loadCount;
        a1 = pcModel + 13'd1;
        queueFetch(pcModel);
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        n = 0;
        while (!(mem_rd === 1'b1 && mem_addr === a1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reached_rd_lo", mem_addr, a1);
        applyReset();
        repeat (10) @(negedge clk);
        checkOutput("abort_no_loads", loadCount - loadsBefore, 0);
        checkOutput("abort_pc", pc_out, 0);
        applyStimulus("post_abort", 0);

        // Back-to-back fetches with fetch_req held high: addresses 0..3.
        applyReset();
        waitStates  = 0;
        loadsBefore = loadCount;
        queueFetch(13'd0);
        queueFetch(13'd2);
        @(negedge clk);
        fetch_req = 1'b1;
        waitFetchDone("b2b_first");
        @(negedge clk);
        checkOutput("b2b_idle_gap_busy", busy, 0);
        checkOutput("b2b_idle_gap_load", load_ir, 0);
        @(negedge clk);
        checkOutput("b2b_second_started", busy, 1);
        fetch_req = 1'b0;
        waitFetchDone("b2b_second");
        @(negedge clk);
        checkOutput("b2b_loads", loadCount - loadsBefore, 4);
        checkOutput("b2b_pc", pc_out, 13'd4);
        checkOutput("b2b_addr_q_empty", expAddrQ.size(), 0);
        checkOutput("b2b_byte_q_empty", expByteQ.size(), 0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port fetch_req, input, 1, start one instruction fetch; sampled only in IDLE.
REQ-004 SHALL have port pc_load, input, 1, load pc_in into PC; honoured only in IDLE.
REQ-005 SHALL have port pc_in, input, 13, new PC value (jump target).
REQ-006 SHALL have port mem_rd, output, 1, byte read request to 8-bit memory.
REQ-007 SHALL have port mem_addr, output, 13, byte address; equals pc_out.
REQ-008 SHALL have port mem_rdata, input, 8, memory read byte; valid when mem_ready=1.
REQ-009 SHALL have port mem_ready, input, 1, read completion; any number of wait cycles allowed.
REQ-010 SHALL have port load_ir, output, 1, byte strobe to instruction register.
REQ-011 SHALL have port ir_data, output, 8, byte presented to instruction register.
REQ-012 SHALL have port pc_out, output, 13, current PC.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port fetch_done, output, 1, one-cycle pulse at end of each fetch.

Function
REQ-015 SHALL implement states IDLE, RD_HI, RD_LO, EMIT_HI, EMIT_LO; all outputs registered.
REQ-016 IDLE: pc_load=1 SHALL set PC=pc_in next cycle; pc_load has priority over fetch_req, which is then ignored that cycle.
REQ-017 IDLE: fetch_req=1 and pc_load=0 SHALL go to RD_HI with mem_rd=1 and mem_addr=PC next cycle.
REQ-018 RD_HI: mem_rd SHALL stay 1 and mem_addr stable until mem_ready=1; on mem_ready, capture mem_rdata as hi byte, PC+1, go RD_LO.
REQ-019 RD_LO: same handshake at new PC; on mem_ready, capture lo byte, PC+1, go EMIT_HI, mem_rd=0.
REQ-020 mem_ready while mem_rd=0 SHALL be ignored.
REQ-021 EMIT_HI: load_ir=1, ir_data=hi byte ({opcode[2:0], addr[12:8]}); next state EMIT_LO.
REQ-022 EMIT_LO: load_ir=1, ir_data=lo byte (addr[7:0]), fetch_done=1; next state IDLE.
REQ-023 load_ir SHALL be high exactly two consecutive cycles per fetch, hi byte first, never at any other time.
REQ-024 Minimum fetch with zero wait states: fetch_req cycle N -> load_ir cycles N+3,N+4 -> busy low N+5.
REQ-025 PC increment SHALL be modulo 2^13 (8191+1 -> 0); wrap between hi and lo reads is legal.
REQ-026 pc_load and fetch_req while busy SHALL have no effect and SHALL NOT be queued.
REQ-027 ir_data SHALL hold its last value when load_ir=0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, PC=0, mem_rd=0, load_ir=0, fetch_done=0, ir_data=0, busy=0, internal byte registers 0.
REQ-029 Reset mid-fetch SHALL abort it with no further load_ir or fetch_done; first post-reset fetch reads address 0.

Verification
REQ-030 Reset then fetch_req, mem 0x0000=0xA5, 0x0001=0x3C, zero waits -> mem_addr 0,1; load_ir 2 cycles with ir_data 0xA5 then 0x3C; pc_out=2; fetch_done with second byte.
REQ-031 Same fetch, mem_ready delayed 3 cycles per byte -> mem_rd and mem_addr held stable throughout waits; output bytes/timing relative to last ready unchanged.
REQ-032 pc_load with pc_in=0x1FFF and fetch_req same cycle -> PC=0x1FFF, no fetch; then fetch -> reads 0x1FFF then 0x0000, pc_out=0x0001.
REQ-033 fetch_req and pc_load (pc_in=0x0100) pulsed during RD_LO -> ignored; PC continues sequentially; exactly one load_ir pair.
REQ-034 rst_n low during RD_LO -> outputs zero immediately; no load_ir pair; next fetch starts at 0x0000.
REQ-035 Two back-to-back fetches (fetch_req held high) -> two separate load_ir pairs with busy-low IDLE cycle between, addresses 0..3 in order.
